// File: rtl/ccd_pattern_gen_if.sv
// Pattern RAM write bus for ccd_pattern_gen.
interface ccd_pattern_gen_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DAC_W  = 14
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DAC_W-1:0]  wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/ccd_pattern_gen.sv
// CCD sensor timing and DAC pattern generator: plays a RAM pattern per line with
// blanking, drives clk_out/shp/shd/clamp/hd/vd, and captures one ADC sample per pixel.
module ccd_pattern_gen #(
    parameter int unsigned DAC_W  = 14,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned REP_W  = 8,
    parameter int unsigned CAP_W  = 12,
    parameter int unsigned BLANK  = 10
) (
    input  logic               sys_clk,
    input  logic               rst,
    ccd_pattern_gen_if.slave   wr_bus,
    input  logic [DAC_W-1:0]   black_level,
    input  logic [REP_W-1:0]   num_reps,
    input  logic [ADDR_W:0]    pattern_len,
    input  logic [15:0]        num_lines,
    input  logic               ccd_mode,
    input  logic               loop_mode,
    input  logic               clamp_en,
    input  logic               start,
    input  logic               stop,
    input  logic [CAP_W-1:0]   adc_q,
    input  logic               adc_valid,
    output logic [DAC_W-1:0]   dac_d,
    output logic               clk_out,
    output logic               shp,
    output logic               shd,
    output logic               clamp,
    output logic               hd,
    output logic               vd,
    output logic               busy,
    output logic               done,
    output logic [CAP_W-1:0]   cap_data,
    output logic               cap_valid
);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned BLANK_W = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int unsigned PIX_W   = (ADDR_W > BLANK_W) ? ADDR_W : BLANK_W;
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_e;

    state_e             state_q, state_d;
    logic [REP_W-1:0]   sub_q, sub_d, n_q, n_d;
    logic               half_q, half_d, stop_q, stop_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [15:0]        line_q, line_d, lines_last_q, lines_last_d;
    logic [ADDR_W-1:0]  len_last_q, len_last_d;
    logic [DAC_W-1:0]   black_q, black_d, dac_q, dac_d_d;
    logic               ccd_q, ccd_d, loop_q, loop_d, clamp_en_q, clamp_en_d;
    logic               clk_out_q, clk_out_d, shp_q, shp_d, shd_q, shd_d;
    logic               clamp_q, clamp_d, hd_q, hd_d, vd_q, vd_d;
    logic               busy_q, busy_d, done_q, done_d, cap_valid_q, cap_valid_d;
    logic [CAP_W-1:0]   cap_data_q, cap_data_d;

    logic [DAC_W-1:0]   pat_mem [DEPTH];
    logic               half_end, pix_end, in_win, in_blank;
    logic [REP_W-1:0]   n_qtr, n_hlf;

    // Pattern RAM: writable only while idle, no reset on contents
    always_ff @(posedge sys_clk) begin
        if (!rst && wr_bus.wr_en && state_q == S_IDLE) begin
            pat_mem[wr_bus.wr_addr] <= wr_bus.wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sub_q        <= '0;
            half_q       <= 1'b0;
            stop_q       <= 1'b0;
            pix_q        <= '0;
            line_q       <= '0;
            n_q          <= '0;
            lines_last_q <= '0;
            len_last_q   <= '0;
            black_q      <= '0;
            ccd_q        <= 1'b0;
            loop_q       <= 1'b0;
            clamp_en_q   <= 1'b0;
            dac_q        <= '0;
            clk_out_q    <= 1'b0;
            shp_q        <= 1'b1;
            shd_q        <= 1'b1;
            clamp_q      <= 1'b0;
            hd_q         <= 1'b1;
            vd_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cap_valid_q  <= 1'b0;
            cap_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            sub_q        <= sub_d;
            half_q       <= half_d;
            stop_q       <= stop_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            n_q          <= n_d;
            lines_last_q <= lines_last_d;
            len_last_q   <= len_last_d;
            black_q      <= black_d;
            ccd_q        <= ccd_d;
            loop_q       <= loop_d;
            clamp_en_q   <= clamp_en_d;
            dac_q        <= dac_d_d;
            clk_out_q    <= clk_out_d;
            shp_q        <= shp_d;
            shd_q        <= shd_d;
            clamp_q      <= clamp_d;
            hd_q         <= hd_d;
            vd_q         <= vd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cap_valid_q  <= cap_valid_d;
            cap_data_q   <= cap_data_d;
        end
    end

    assign half_end = (sub_q == n_q - REP_W'(1));
    assign pix_end  = half_end && half_q;

    // Sequencing; outputs are derived from the next-state values so they align with state
    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        half_d       = half_q;
        stop_d       = stop_q;
        pix_d        = pix_q;
        line_d       = line_q;
        n_d          = n_q;
        lines_last_d = lines_last_q;
        len_last_d   = len_last_q;
        black_d      = black_q;
        ccd_d        = ccd_q;
        loop_d       = loop_q;
        clamp_en_d   = clamp_en_q;
        done_d       = 1'b0;
        cap_valid_d  = 1'b0;
        cap_data_d   = cap_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_ACTIVE;
                    sub_d        = '0;
                    half_d       = 1'b0;
                    stop_d       = 1'b0;
                    pix_d        = '0;
                    line_d       = '0;
                    n_d          = (num_reps < REP_W'(4)) ? REP_W'(4) : num_reps;
                    lines_last_d = (num_lines == 16'd0) ? 16'd0 : num_lines - 16'd1;
                    len_last_d   = (pattern_len == '0 || pattern_len > DEPTH_L) ? '1
                                 : ADDR_W'(pattern_len - (ADDR_W+1)'(1));
                    black_d      = black_level;
                    ccd_d        = ccd_mode;
                    loop_d       = loop_mode;
                    clamp_en_d   = clamp_en;
                end
            end
            default: begin
                if (stop) stop_d = 1'b1;
                if (!half_end) begin
                    sub_d = sub_q + REP_W'(1);
                end else begin
                    sub_d  = '0;
                    half_d = ~half_q;
                end
                if (pix_end && state_q == S_ACTIVE && adc_valid) begin
                    cap_valid_d = 1'b1;
                    cap_data_d  = adc_q;
                end
                // Pixel boundary: a pending stop overrides every line/frame transition
                if (pix_end) begin
                    if (stop_q || stop) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                        pix_d   = '0;
                        line_d  = '0;
                    end else if (state_q == S_ACTIVE) begin
                        if (pix_q == PIX_W'(len_last_q)) begin
                            state_d = S_BLANK;
                            pix_d   = '0;
                        end else begin
                            pix_d = pix_q + PIX_W'(1);
                        end
                    end else if (pix_q != PIX_W'(BLANK - 1)) begin
                        pix_d = pix_q + PIX_W'(1);
                    end else begin
                        pix_d = '0;
                        if (line_q != lines_last_q) begin
                            state_d = S_ACTIVE;
                            line_d  = line_q + 16'd1;
                        end else if (loop_q) begin
                            state_d = S_ACTIVE;
                            line_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            line_d  = '0;
                        end
                    end
                end
            end
        endcase
    end

    assign n_qtr    = n_d >> 2;
    assign n_hlf    = n_d >> 1;
    assign in_win   = (sub_d >= n_qtr) && (sub_d < n_qtr + n_hlf);
    assign in_blank = (state_d == S_BLANK);

    // Registered sensor timing and DAC code
    always_comb begin
        dac_d_d   = dac_q;
        clk_out_d = 1'b0;
        shp_d     = 1'b1;
        shd_d     = 1'b1;
        clamp_d   = 1'b0;
        hd_d      = 1'b1;
        vd_d      = 1'b1;
        busy_d    = 1'b0;
        if (state_d != S_IDLE) begin
            busy_d    = 1'b1;
            clk_out_d = ~half_d;
            shp_d     = !(!half_d && in_win);
            shd_d     = !(half_d && in_win);
            clamp_d   = in_blank && clamp_en_d;
            hd_d      = !(in_blank && pix_d == '0);
            vd_d      = !(in_blank && line_d == lines_last_d);
            dac_d_d   = (in_blank || (ccd_d && !half_d)) ? black_d
                      : pat_mem[pix_d[ADDR_W-1:0]];
        end
    end

    assign dac_d     = dac_q;
    assign clk_out   = clk_out_q;
    assign shp       = shp_q;
    assign shd       = shd_q;
    assign clamp     = clamp_q;
    assign hd        = hd_q;
    assign vd        = vd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cap_data  = cap_data_q;
    assign cap_valid = cap_valid_q;
endmodule

// File: tb/tb_ccd_pattern_gen.sv
// Directed bench for ccd_pattern_gen: expected waveforms are derived per cycle from
// the pixel offset relative to the first clk_out rise after start.
module tb_ccd_pattern_gen;
    localparam int unsigned DAC_W  = 14;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned REP_W  = 8;
    localparam int unsigned CAP_W  = 12;
    localparam int unsigned BLANK  = 2;

    logic               sys_clk = 1'b0;
    logic               rst;
    logic [DAC_W-1:0]   black_level;
    logic [REP_W-1:0]   num_reps;
    logic [ADDR_W:0]    pattern_len;
    logic [15:0]        num_lines;
    logic               ccd_mode, loop_mode, clamp_en, start, stop;
    logic [CAP_W-1:0]   adc_q;
    logic               adc_valid;
    logic [DAC_W-1:0]   dac_d;
    logic               clk_out, shp, shd, clamp, hd, vd, busy, done;
    logic [CAP_W-1:0]   cap_data;
    logic               cap_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int pat [8];

    ccd_pattern_gen_if #(.ADDR_W(ADDR_W), .DAC_W(DAC_W)) wr_if ();

    ccd_pattern_gen #(
        .DAC_W(DAC_W), .ADDR_W(ADDR_W), .REP_W(REP_W), .CAP_W(CAP_W), .BLANK(BLANK)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .wr_bus(wr_if.slave),
        .black_level(black_level), .num_reps(num_reps), .pattern_len(pattern_len),
        .num_lines(num_lines), .ccd_mode(ccd_mode), .loop_mode(loop_mode),
        .clamp_en(clamp_en), .start(start), .stop(stop), .adc_q(adc_q),
        .adc_valid(adc_valid), .dac_d(dac_d), .clk_out(clk_out), .shp(shp),
        .shd(shd), .clamp(clamp), .hd(hd), .vd(vd), .busy(busy), .done(done),
        .cap_data(cap_data), .cap_valid(cap_valid)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic idle_check(input string tag, input int exp_dac, input bit exp_done);
        check({tag, " busy"},    32'(busy),    32'(0));
        check({tag, " clk_out"}, 32'(clk_out), 32'(0));
        check({tag, " shp"},     32'(shp),     32'(1));
        check({tag, " shd"},     32'(shd),     32'(1));
        check({tag, " hd"},      32'(hd),      32'(1));
        check({tag, " vd"},      32'(vd),      32'(1));
        check({tag, " clamp"},   32'(clamp),   32'(0));
        check({tag, " done"},    32'(done),    32'(exp_done));
        check({tag, " dac"},     32'(dac_d),   32'(exp_dac));
    endtask

    task automatic write_ram(input int a, input int d);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_addr = ADDR_W'(a);
        wr_if.wr_data = DAC_W'(d);
        tick();
        wr_if.wr_en   = 1'b0;
    endtask

    task automatic kick(input int reps, input int plen, input int nl, input bit ccd,
                        input bit lp, input bit ce, input int black);
        num_reps    = REP_W'(reps);
        pattern_len = (ADDR_W+1)'(plen);
        num_lines   = 16'(nl);
        ccd_mode    = ccd;
        loop_mode   = lp;
        clamp_en    = ce;
        black_level = DAC_W'(black);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Walks the frame cycle by cycle from c0 of line 0, pixel 0
    task automatic run_check(input int n, input int plen, input int nl, input bit ccd,
                             input bit ce, input int black, input int cycles,
                             input int stop_at, input int poke_at);
        int ppl, line_cyc, off, pil, line, sub, pp, exp_dac;
        bit act, half, win, blank, capv;
        ppl      = plen + BLANK;
        line_cyc = ppl * 2 * n;
        for (int t = 0; t < cycles; t++) begin
            off   = t % (2 * n);
            pil   = (t / (2 * n)) % ppl;
            line  = (t / line_cyc) % nl;
            act   = (pil < plen);
            blank = !act;
            half  = (off >= n);
            sub   = off % n;
            win   = (sub >= n / 4) && (sub < n / 4 + n / 2);
            exp_dac = (blank || (ccd && !half)) ? black : pat[pil];
            capv = 1'b0;
            pp   = 0;
            if (t > 0 && off == 0) begin
                pp   = ((t - 1) / (2 * n)) % ppl;
                capv = (pp < plen);
            end
            check($sformatf("busy t=%0d", t),    32'(busy),    32'(1));
            check($sformatf("clk_out t=%0d", t), 32'(clk_out), 32'(!half));
            check($sformatf("shp t=%0d", t),     32'(shp),     32'(!(!half && win)));
            check($sformatf("shd t=%0d", t),     32'(shd),     32'(!(half && win)));
            check($sformatf("dac t=%0d", t),     32'(dac_d),   32'(exp_dac));
            check($sformatf("clamp t=%0d", t),   32'(clamp),   32'(blank && ce));
            check($sformatf("hd t=%0d", t),      32'(hd),      32'(!(blank && pil == plen)));
            check($sformatf("vd t=%0d", t),      32'(vd),      32'(!(blank && line == nl - 1)));
            check($sformatf("done t=%0d", t),    32'(done),    32'(0));
            check($sformatf("cap_valid t=%0d", t), 32'(cap_valid), 32'(capv));
            if (capv) check($sformatf("cap_data t=%0d", t), 32'(cap_data), 32'(pp));
            adc_q         = CAP_W'(pil);
            adc_valid     = 1'b1;
            stop          = (t == stop_at);
            start         = (t == poke_at);
            wr_if.wr_en   = (t == poke_at);
            wr_if.wr_addr = '0;
            wr_if.wr_data = DAC_W'(999);
            tick();
        end
        stop        = 1'b0;
        start       = 1'b0;
        wr_if.wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        black_level = '0; num_reps = '0; pattern_len = '0; num_lines = '0;
        ccd_mode = 1'b0; loop_mode = 1'b0; clamp_en = 1'b0; start = 1'b0; stop = 1'b0;
        adc_q = '0; adc_valid = 1'b0;
        wr_if.wr_en = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
        tick();
        tick();
        idle_check("reset", 0, 1'b0);
        check("reset cap_valid", 32'(cap_valid), 32'(0));
        check("reset cap_data",  32'(cap_data),  32'(0));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pat[i] = i + 1;
            write_ram(i, pat[i]);
        end

        // CCD mode, N=8, 4 pixels, one line
        kick(8, 4, 1, 1'b1, 1'b0, 1'b1, 100);
        run_check(8, 4, 1, 1'b1, 1'b1, 100, 96, -1, -1);
        idle_check("ccd end", 100, 1'b1);
        check("ccd end cap_valid", 32'(cap_valid), 32'(0));
        tick();
        check("ccd done pulse", 32'(done), 32'(0));

        // Plain mode, num_reps=2 clamps to N=4
        kick(2, 3, 1, 1'b0, 1'b0, 1'b0, 50);
        run_check(4, 3, 1, 1'b0, 1'b0, 50, 40, -1, -1);
        idle_check("plain end", 50, 1'b1);
        tick();
        check("plain done pulse", 32'(done), 32'(0));

        // Looping two-line frame, stop mid-pixel in the third frame
        kick(4, 2, 2, 1'b1, 1'b1, 1'b1, 60);
        run_check(4, 2, 2, 1'b1, 1'b1, 60, 136, 131, -1);
        idle_check("stop end", pat[0], 1'b1);
        check("stop cap_valid", 32'(cap_valid), 32'(1));
        check("stop cap_data",  32'(cap_data),  32'(0));
        tick();
        check("stop done pulse", 32'(done), 32'(0));
        check("stop busy",       32'(busy), 32'(0));

        // pattern_len=0 -> 8 pixels, num_lines=0 -> 1, N=5; start/wr_en while busy
        kick(5, 0, 0, 1'b0, 1'b0, 1'b0, 70);
        run_check(5, 8, 1, 1'b0, 1'b0, 70, 100, -1, 20);
        idle_check("len0 end", 70, 1'b1);
        tick();

        // RAM word 0 untouched by the busy write; then reset mid-active with start
        kick(4, 0, 1, 1'b0, 1'b0, 1'b0, 30);
        run_check(4, 8, 1, 1'b0, 1'b0, 30, 19, -1, -1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        idle_check("mid rst", 0, 1'b0);
        check("mid rst cap_valid", 32'(cap_valid), 32'(0));
        check("mid rst cap_data",  32'(cap_data),  32'(0));
        rst   = 1'b0;
        start = 1'b0;
        tick();
        idle_check("post rst", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ccd_pattern_gen.md
CCD_PATTERN_GEN -- requirements
Module: ccd_pattern_gen

Interface
REQ-001 The block SHALL have these parameters: DAC_W, default 14, DAC/sample width; ADDR_W, default 8, pattern RAM address width (depth 2^ADDR_W); REP_W, default 8, cycles-per-half-pixel width; CAP_W, default 12, capture width; BLANK, default 10, blanking pixels per line.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Port: sys_clk  in  1  sole clock.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: wr_en / wr_addr / wr_data  in  1 / ADDR_W / DAC_W  pattern RAM write port.
REQ-006 Port: black_level  in  DAC_W  black-phase DAC code.
REQ-007 Port: num_reps  in  REP_W  half-pixel length N in cycles.
REQ-008 Port: pattern_len  in  ADDR_W+1  active pixels per line.
REQ-009 Port: num_lines  in  16  lines per frame.
REQ-010 Port: ccd_mode, loop_mode, clamp_en  in  1 each  mode controls.
REQ-011 Port: start, stop  in  1 each  single-cycle command pulses.
REQ-012 Port: adc_q  in  CAP_W; adc_valid  in  1  returned ADC data.
REQ-013 Port: dac_d  out  DAC_W  DAC code.
REQ-014 Port: clk_out, shp, shd, clamp, hd, vd  out  1 each  sensor timing.
REQ-015 Port: busy, done  out  1 each  status; done is a 1-cycle pulse.
REQ-016 Port: cap_data  out  CAP_W; cap_valid  out  1  captured sample.

Function
REQ-017 States SHALL be IDLE, ACTIVE, BLANKING; busy=1 in ACTIVE and BLANKING only.
REQ-018 RAM writes SHALL take effect only in IDLE; wr_en while busy is ignored.
REQ-019 start in IDLE SHALL latch all config inputs and enter ACTIVE at line 0, pixel 0; start while busy is ignored.
REQ-020 Latched N SHALL be max(num_reps,4); pattern_len=0 means 2^ADDR_W; num_lines=0 means 1.
REQ-021 Each pixel SHALL last 2N cycles; c0 = the cycle clk_out rises; pixels are back-to-back with no gap.
REQ-022 clk_out SHALL be 1 in c0..c0+N-1 and 0 in c0+N..c0+2N-1.
REQ-023 shp SHALL be 0 in c0+floor(N/4)..c0+floor(N/4)+floor(N/2)-1 and 1 otherwise.
REQ-024 shd SHALL be 0 in c0+N+floor(N/4)..c0+N+floor(N/4)+floor(N/2)-1 and 1 otherwise.
REQ-025 ccd_mode=1 in ACTIVE: dac_d SHALL be black_level in c0..c0+N-1 and pattern[k] in c0+N..c0+2N-1 for pixel k.
REQ-026 ccd_mode=0 in ACTIVE: dac_d SHALL be pattern[k] for the whole pixel.
REQ-027 After pixel pattern_len-1, the state SHALL go to BLANKING for BLANK pixels; dac_d=black_level; clk_out, shp, shd keep pulsing.
REQ-028 clamp SHALL equal clamp_en in BLANKING and 0 otherwise.
REQ-029 hd SHALL be 0 during the first pixel of each BLANKING interval and 1 otherwise.
REQ-030 vd SHALL be 0 during the whole BLANKING interval of the last line and 1 otherwise.
REQ-031 After BLANKING of a non-last line: go to ACTIVE with the next line.
REQ-032 After BLANKING of the last line: loop_mode=0 -> go to IDLE with done=1 for one cycle; loop_mode=1 -> restart at line 0 with no gap.
REQ-033 stop while busy SHALL finish the current pixel, then go to IDLE with done=1; stop has priority over the REQ-031/REQ-032 transitions.
REQ-034 Capture: if adc_valid=1 in cycle c0+2N-1 of an ACTIVE pixel, cap_data SHALL take adc_q and cap_valid SHALL pulse 1 in the next cycle; no capture in BLANKING or IDLE.
REQ-035 In IDLE: clk_out=0, shp=shd=hd=vd=1, clamp=0, dac_d holds its last value.
REQ-036 Pixel, line and phase counters SHALL wrap only as defined above; no arithmetic overflow at the maximum N, pattern_len or num_lines.

Reset
REQ-037 With rst=1 at any clock edge, including mid-frame, the next state SHALL be IDLE with dac_d=0, clk_out=0, shp=shd=1, clamp=0, hd=vd=1, busy=0, done=0, cap_valid=0, cap_data=0, all counters 0.
REQ-038 RAM contents are undefined after reset and SHALL NOT be relied on; rst has priority over start, stop and wr_en.

Verification
REQ-039 CCD mode: N=8, pattern_len=4, RAM={1,2,3,4}, black=100, BLANK=2, num_lines=1 -> per pixel dac_d 100x8 then k+1 x8; shp low c0+2..c0+5; shd low c0+10..c0+13; hd low 16 cycles after pixel 3; done once.
REQ-040 Plain mode: N=2 -> N clamped to 4; each pixel is 8 cycles; dac_d constant per pixel.
REQ-041 loop_mode=1, num_lines=2: vd low only in line-1 blanking, repeating; stop mid-pixel -> pixel completes, done, IDLE.
REQ-042 adc_valid held 1 with adc_q=pixel index -> one cap_valid per active pixel and none in blanking.
REQ-043 rst asserted mid-ACTIVE -> all outputs at REQ-037 values the next cycle; a start pulse during rst is ignored.
REQ-044 pattern_len=0 with ADDR_W=3 -> 8 active pixels; start and wr_en while busy -> no effect.
